// File: rtl/multiplication.sv
// Sequential unsigned shift-and-add multiplier: N-bit x N-bit -> 2N-bit product,
// one multiplier bit per TEST/SHIFT pair, result held in DONE until reset.
module multiplication #(
  parameter int N = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic [N-1:0]   Multiplicant,
  input  logic [N-1:0]   Multiplier,
  output logic [2*N-1:0] Product
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, TEST, SHIFT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  m, a, q;
  logic          c;
  logic [CW-1:0] count;

  logic [N:0]     sum;
  logic [2*N-1:0] shifted;

  assign sum     = {1'b0, a} + {1'b0, m};
  // {C,A,Q} >> 1 with zero into C: the surviving 2N bits become the new {A,Q}
  assign shifted = {c, a, q[N-1:1]};

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= IDLE;
      Product <= '0;
      m       <= '0;
      a       <= '0;
      q       <= '0;
      c       <= 1'b0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            m     <= Multiplicant;
            q     <= Multiplier;
            a     <= '0;
            c     <= 1'b0;
            count <= '0;
            state <= TEST;
          end
        end
        TEST: begin
          if (q[0]) {c, a} <= sum;
          state <= SHIFT;
        end
        SHIFT: begin
          c <= 1'b0;
          a <= shifted[2*N-1:N];
          q <= shifted[N-1:0];
          if (count == LAST) begin
            Product <= shifted;
            state   <= DONE;
          end else begin
            count <= count + 1'b1;
            state <= TEST;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplication.sv
// Directed bench for the shift-and-add multiplier: latency, hold, boundaries,
// mid-operation operand change and mid-operation reset.
module tb_multiplication;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Multiplicant = '0;
  logic [3:0] Multiplier = '0;
  logic [7:0] Product;

  int checks = 0;
  int errors = 0;

  multiplication #(.N(4)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .Multiplicant(Multiplicant),
    .Multiplier(Multiplier),
    .Product(Product)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one rising edge, settle past it
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    step();
    chk("reset", Product, 8'd0);
    Reset = 1'b1;
  endtask

  // reset (Start already high, so reset must win), then 9 edges to the result
  task automatic run(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp, input string tag);
    Multiplicant = x;
    Multiplier   = y;
    Start        = 1'b1;
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      step();
      chk({tag, "_partial"}, Product, 8'd0);
    end
    step();
    chk(tag, Product, exp);
    for (int e = 0; e < 3; e++) begin
      step();
      chk({tag, "_hold"}, Product, exp);
    end
  endtask

  initial begin
    step();
    do_reset();

    run(4'd13, 4'd13, 8'd169, "13x13");
    run(4'd9,  4'd11, 8'd99,  "9x11");
    run(4'd2,  4'd2,  8'd4,   "2x2");
    run(4'd5,  4'd8,  8'd40,  "5x8");
    run(4'd3,  4'd14, 8'd42,  "3x14");
    run(4'd15, 4'd15, 8'd225, "15x15");
    run(4'd0,  4'd15, 8'd0,   "0x15");
    run(4'd15, 4'd0,  8'd0,   "15x0");
    run(4'd1,  4'd1,  8'd1,   "1x1");
    run(4'd12, 4'd10, 8'd120, "12x10");

    // operands change after the start edge: must not affect the result
    Multiplicant = 4'd7;
    Multiplier   = 4'd6;
    Start        = 1'b1;
    do_reset();
    step();
    step();
    Multiplicant = 4'd15;
    Multiplier   = 4'd15;
    for (int e = 3; e <= 8; e++) step();
    chk("opchg_partial", Product, 8'd0);
    step();
    chk("opchg", Product, 8'd42);

    // reset in the middle of an operation, then a fresh run
    Multiplicant = 4'd13;
    Multiplier   = 4'd13;
    do_reset();
    for (int e = 1; e <= 4; e++) step();
    Reset = 1'b0;
    step();
    chk("midrst", Product, 8'd0);
    Reset = 1'b1;
    Multiplicant = 4'd5;
    Multiplier   = 4'd8;
    for (int e = 1; e <= 8; e++) step();
    chk("midrst_partial", Product, 8'd0);
    step();
    chk("midrst_5x8", Product, 8'd40);

    // idle with Start low: nothing happens, then a normal run
    Start = 1'b0;
    Multiplicant = 4'd11;
    Multiplier   = 4'd7;
    do_reset();
    for (int e = 0; e < 20; e++) begin
      step();
      chk("idle", Product, 8'd0);
    end
    Start = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk("idle_partial", Product, 8'd0);
    end
    step();
    chk("idle_11x7", Product, 8'd77);
    step();
    chk("idle_11x7_hold", Product, 8'd77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplication.md
Name: multiplication

Overview:
- Sequential unsigned shift-and-add multiplier: one 4-bit Multiplicant times one 4-bit Multiplier gives an 8-bit Product.
- Performs one multiplication per reset/start cycle, one multiplier bit per two clock cycles.
- Standalone datapath+controller block, driven by a simple level Start and cleared by the active-low Reset.

Parameters:
- N, 4, operand width; Product is 2N bits. All behaviour below is stated for N=4.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising Clock edge.
- Start  input  1  level request; sampled only in IDLE.
- Multiplicant  input  N  unsigned multiplicand; latched on the start edge.
- Multiplier  input  N  unsigned multiplier; latched on the start edge.
- Product  output  2N  registered unsigned result.

Behaviour:
- Reset:
  - On any rising edge with Reset=0: state=IDLE, Product=0, internal registers (M, A, Q, C, count)=0.
  - Reset is synchronous and overrides everything, including mid-operation; the aborted result is discarded.
- Internal registers:
  - M: N-bit latched multiplicand.
  - A: N-bit accumulator (upper half).
  - Q: N-bit shifted multiplier (lower half).
  - C: 1-bit carry.
  - count: 2-bit (log2 N) bit counter.
- States: IDLE, TEST, SHIFT, DONE (binary encoding free).
- IDLE:
  - If Start=1: M<=Multiplicant, Q<=Multiplier, A<=0, C<=0, count<=0, go to TEST.
  - Else remain. Product is unchanged in IDLE (0 after reset).
- TEST:
  - If Q[0]=1, {C,A} <= A + M as a 5-bit sum; else {C,A} unchanged.
  - Go to SHIFT.
- SHIFT:
  - {C,A,Q} <= {C,A,Q} >> 1, with 0 shifted into C.
  - If count==N-1: go to DONE and load Product with the post-shift {A,Q}, computed from the same edge's shift.
  - Else count<=count+1, go to TEST.
- DONE:
  - Product holds the result.
  - Start is ignored; a held-high Start does not restart.
  - Remains in DONE until Reset=0. A new multiplication requires Reset low for at least one edge, then Start.
- Latency:
  - Start-sampling edge = edge 1; Product is valid after edge 2N+1 = 9.
  - Product stays stable until the next reset.
- Operand handling:
  - Operands are used only at the start edge; later changes have no effect on the running or completed operation.
- Arithmetic:
  - Unsigned only. The carry C guarantees no overflow; max result 15*15=225 fits in 8 bits.
- Product is never driven with partial values; it is only 0 or a final result.
- Start=1 coincident with Reset=0: reset wins; Start is re-sampled on the next edge with Reset=1.

Test Plan:
- Reset=0 one cycle, then Reset=1, Start=1 held, Multiplicant=13, Multiplier=13 -> Product=0 through edge 8, Product=169 after edge 9, stable for the remaining cycles with Start still high.
- Repeat the reset/start sequence with 9*11, 2*2, 5*8, 3*14 -> Product=99, 4, 40, 42 respectively, each valid 9 edges after Start sampled; Product=0 during each reset cycle.
- Boundaries:
  - 15*15 -> 225.
  - 0*15 and 15*0 -> 0.
  - 1*1 -> 1.
- Operand change mid-operation: start 7*6, change inputs to 15*15 on edge 3 -> Product=42.
- Reset mid-operation: start 13*13, Reset=0 at edge 5 -> Product=0, state IDLE; then Start with 5*8 -> 40 after 9 edges.
- Start=0 after reset for 20 cycles -> Product stays 0, no state change; Start then asserted -> normal 9-edge completion.
